io_bank_arbiter: RTL and testbench
==================================

// Module: io_bank_arbiter
// PURPOSE
//  Time-shares one group of fabric user IOs (io_in/io_out/io_oeb, oeb=1 -> pad tri-stated)
//  among NUM_REQ internal requesters. Round-robin grant, enforced bus turnaround with all
//  pins tri-stated between owners, and a bounded hold time per grant.
//  Sits inside a user design between its logic and the IO_1_bidirectional BEL pins.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  WIDTH       8   number of shared IO pins
//  TURN_CYCLES 1   tri-state cycles inserted before each ownership (0..15)
//  MAX_HOLD    15  max OWN cycles per grant before forced release (1..255)
// PORTS
//  clk     in   1              fabric global clock
//  rst     in   1              asynchronous reset, active-high
//  req     in   NUM_REQ        level request; hold high for the whole transaction
//  wr      in   NUM_REQ        per requester: 1 = drive pins, 0 = sample pins
//  wdata   in   NUM_REQ*WIDTH  drive data; requester i owns bits [i*WIDTH +: WIDTH]
//  grant   out  NUM_REQ        one-hot owner, 0 when no owner
//  done    out  NUM_REQ        1-cycle pulse to owner on release
//  rdata   out  WIDTH          last sampled io_in
//  busy    out  1              state != IDLE
//  io_in   in   WIDTH          pad input values
//  io_out  out  WIDTH          pad output values
//  io_oeb  out  WIDTH          pad output enable, active-low
// BEHAVIOUR
//  Reset (async, all registers): state=IDLE, grant=0, done=0, rdata=0, io_out=0,
//   io_oeb=all 1, rr pointer=0, counters=0. Reset mid-transaction: pins tri-state at once,
//   no done pulse.
//  All outputs are registered.
//  FSM: IDLE -> TURN -> OWN -> IDLE
//  IDLE: if any req, choose winner = first set req at or after rr pointer, mod NUM_REQ.
//   Next cycle: grant=onehot(winner). Go to TURN with tcnt=TURN_CYCLES, or straight to
//   OWN if TURN_CYCLES=0.
//  TURN: io_oeb=all 1, io_out=0. Decrement tcnt; when tcnt==1 go to OWN.
//   If req[owner] drops during TURN: abort. Pulse done[owner], clear grant, go to IDLE.
//  OWN, each cycle (registered, visible next cycle):
//   - io_out <= wdata[owner], io_oeb <= {WIDTH{~wr[owner]}}
//   - if !wr[owner]: rdata <= io_in
//   - hold++
//   Exit condition: req[owner]==0, or hold reaches MAX_HOLD.
//   On exit, next cycle: done[owner]=1 for 1 cycle, grant=0, io_oeb=all 1, io_out=0,
//   hold=0, rr pointer=(owner+1)%NUM_REQ, state=IDLE.
//  Latency: req rises in IDLE at cycle 0 -> grant at 1 -> OWN entered at 1+TURN_CYCLES
//   -> pins driven at 2+TURN_CYCLES.
//  Min gap between owners: 1 IDLE cycle + TURN_CYCLES, with pins tri-stated throughout.
//  Requests that change in the same cycle as an exit are seen by IDLE on the next cycle.
//   Wrap-around: pointer at NUM_REQ-1 continues at 0.
//  Forced release (MAX_HOLD): a requester still holding req re-arbitrates normally.
//   It goes behind the other requesters because the rr pointer has advanced.
//  grant is never multi-hot. io_oeb is never 0 while grant==0.
// TESTING
//  1 Reset: assert rst mid-OWN -> same cycle io_oeb=8'hFF, grant=0, busy=0. No done pulse.
//  2 Single write: req[2]=1, wr[2]=1, wdata[2]=8'hA5 for 4 cycles
//    -> grant=4'b0100 at c1; io_oeb=00, io_out=A5 from c3.
//    req drops -> done[2] pulse; io_oeb=FF next cycle.
//  3 Round robin: req=4'b1111 held
//    -> grants in order 0,1,2,3,0 with MAX_HOLD=15 OWN cycles each.
//    FF tri-state gap of >=2 cycles between owners.
//  4 Read: req[1]=1, wr[1]=0, io_in=8'h3C
//    -> io_oeb stays FF throughout; rdata=3C one cycle after OWN entry.
//  5 Abort in TURN: TURN_CYCLES=3, req[0] drops at c2 -> done[0] at c3, busy=0, pins never driven.
//  6 Pointer wrap: owner=3 releases with req=4'b1001 -> next grant=4'b0001.
//    Property checks: grant one-hot-or-zero; io_oeb!=FF implies grant!=0.

Source files
------------

// File: rtl/io_bank_arbiter.sv
// Round-robin arbiter that time-shares one bank of bidirectional user IOs among NUM_REQ
// requesters, with tri-stated turnaround between owners and a bounded hold per grant.
module io_bank_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       wr,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         rdata,
  output logic                     busy,
  input  logic [WIDTH-1:0]         io_in,
  output logic [WIDTH-1:0]         io_out,
  output logic [WIDTH-1:0]         io_oeb
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TURN,
    ST_OWN
  } state_t;

  state_t             r_state;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      r_ptr;
  logic [3:0]         r_tcnt;
  logic [7:0]         r_hold;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic [WIDTH-1:0]   r_rdata;
  logic [WIDTH-1:0]   r_io_out;
  logic [WIDTH-1:0]   r_io_oeb;

  logic               w_found;
  logic [IW-1:0]      w_winner;
  logic [IW:0]        w_sum;
  logic [IW-1:0]      w_idx;
  logic               w_owner_req;
  logic               w_owner_wr;
  logic [WIDTH-1:0]   w_owner_wdata;
  logic               w_hold_last;
  logic [IW-1:0]      w_ptr_next;
  logic [WIDTH-1:0]   w_wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_wdata_arr[g] = wdata[g*WIDTH +: WIDTH];
  end

  // First set request at or after the rr pointer, scanning with wrap-around.
  // NOTE: every signal driven here gets a default before the loop so no latch is inferred.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ)) w_sum = w_sum - (IW+1)'(NUM_REQ);
      w_idx = w_sum[IW-1:0];
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_owner_req   = req[r_owner];
  assign w_owner_wr    = wr[r_owner];
  assign w_owner_wdata = w_wdata_arr[r_owner];
  assign w_hold_last   = (r_hold == 8'(MAX_HOLD - 1));
  assign w_ptr_next    = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  // NOTE: state registers use non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_tcnt   <= '0;
      r_hold   <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_rdata  <= '0;
      r_io_out <= '0;
      r_io_oeb <= '1;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_owner <= w_winner;
            r_grant <= NUM_REQ'(1) << w_winner;
            r_hold  <= '0;
            if (TURN_CYCLES == 0) begin
              r_state <= ST_OWN;
            end else begin
              r_state <= ST_TURN;
              r_tcnt  <= 4'(TURN_CYCLES);
            end
          end
        end
        ST_TURN: begin
          r_io_oeb <= '1;
          r_io_out <= '0;
          if (!w_owner_req) begin
            // Owner gave up before touching the pins; rr pointer stays where it was.
            r_done  <= r_grant;
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_tcnt <= r_tcnt - 4'd1;
            if (r_tcnt == 4'd1) r_state <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!w_owner_wr) r_rdata <= io_in;
          if (!w_owner_req || w_hold_last) begin
            r_done   <= r_grant;
            r_grant  <= '0;
            r_io_oeb <= '1;
            r_io_out <= '0;
            r_hold   <= '0;
            r_ptr    <= w_ptr_next;
            r_state  <= ST_IDLE;
          end else begin
            r_io_out <= w_owner_wdata;
            r_io_oeb <= {WIDTH{~w_owner_wr}};
            r_hold   <= r_hold + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant  = r_grant;
  assign done   = r_done;
  assign rdata  = r_rdata;
  assign busy   = (r_state != ST_IDLE);
  assign io_out = r_io_out;
  assign io_oeb = r_io_oeb;

endmodule

// File: tb/tb_io_bank_arbiter.sv
// Bench for io_bank_arbiter: two instances (turnaround 1 and 3) share stimulus and are
// compared every cycle against a transaction-level ownership model, plus directed scenarios.
module tb_io_bank_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int TC_A = 1, MH_A = 15;
  localparam int TC_B = 3, MH_B = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, wr;
  logic [N*W-1:0] wdata;
  logic [W-1:0]   io_in;

  logic [N-1:0]   grant_a, done_a, grant_b, done_b;
  logic [W-1:0]   rdata_a, io_out_a, io_oeb_a, rdata_b, io_out_b, io_oeb_b;
  logic           busy_a, busy_b;

  io_bank_arbiter #(.NUM_REQ(N), .WIDTH(W), .TURN_CYCLES(TC_A), .MAX_HOLD(MH_A)) u_dut_a (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .wdata(wdata),
    .grant(grant_a), .done(done_a), .rdata(rdata_a), .busy(busy_a),
    .io_in(io_in), .io_out(io_out_a), .io_oeb(io_oeb_a)
  );

  io_bank_arbiter #(.NUM_REQ(N), .WIDTH(W), .TURN_CYCLES(TC_B), .MAX_HOLD(MH_B)) u_dut_b (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .wdata(wdata),
    .grant(grant_b), .done(done_b), .rdata(rdata_b), .busy(busy_b),
    .io_in(io_in), .io_out(io_out_b), .io_oeb(io_oeb_b)
  );

  always #5 clk = ~clk;

  // Ownership model: who owns the bank, how many turnaround cycles remain, how long it has held.
  typedef struct {
    int         owner;
    int         turn_left;
    int         held;
    int         ptr;
    logic [3:0] grant;
    logic [3:0] done;
    logic [7:0] rdata;
    logic [7:0] io_out;
    logic [7:0] io_oeb;
    logic       busy;
  } model_t;

  model_t m_a, m_b;
  int     n_chk = 0;
  int     n_err = 0;
  int     rem [N];

  function automatic model_t model_reset();
    model_t m;
    m.owner = -1; m.turn_left = 0; m.held = 0; m.ptr = 0;
    m.grant = '0; m.done = '0; m.rdata = '0; m.io_out = '0; m.io_oeb = 8'hFF; m.busy = 1'b0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, int tc, int mh, logic [3:0] rq,
                                        logic [3:0] wv, logic [31:0] wd, logic [7:0] din);
    model_t n = m;
    n.done = '0;
    if (m.owner < 0) begin
      if (rq != 4'b0) begin
        int w = m.ptr;
        while (!rq[w]) w = (w + 1) % N;
        n.owner = w; n.grant = 4'b0001 << w; n.turn_left = tc; n.held = 0;
      end
    end else if (m.turn_left > 0) begin
      if (!rq[m.owner]) begin
        n.done = m.grant; n.grant = '0; n.owner = -1;
      end else begin
        n.turn_left = m.turn_left - 1;
      end
    end else begin
      n.held = m.held + 1;
      if (!wv[m.owner]) n.rdata = din;
      if (!rq[m.owner] || n.held == mh) begin
        n.done = m.grant; n.grant = '0; n.io_oeb = 8'hFF; n.io_out = '0;
        n.ptr = (m.owner + 1) % N; n.held = 0; n.owner = -1;
      end else begin
        n.io_out = wd[m.owner*8 +: 8];
        n.io_oeb = wv[m.owner] ? 8'h00 : 8'hFF;
      end
    end
    n.busy = (n.owner >= 0);
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_dut(input string p, input logic [3:0] g, input logic [3:0] d,
                             input logic [7:0] rd, input logic [7:0] io, input logic [7:0] oe,
                             input logic b, input model_t m);
    check({p, "_grant"}, 32'(g), 32'(m.grant));
    check({p, "_done"}, 32'(d), 32'(m.done));
    check({p, "_rdata"}, 32'(rd), 32'(m.rdata));
    check({p, "_io_out"}, 32'(io), 32'(m.io_out));
    check({p, "_io_oeb"}, 32'(oe), 32'(m.io_oeb));
    check({p, "_busy"}, 32'(b), 32'(m.busy));
    check({p, "_onehot0"}, 32'($onehot0(g)), 32'd1);
    check({p, "_drive_without_grant"}, 32'((oe != 8'hFF) && (g == 4'b0)), 32'd0);
  endtask

  task automatic compare_all();
    compare_dut("a", grant_a, done_a, rdata_a, io_out_a, io_oeb_a, busy_a, m_a);
    compare_dut("b", grant_b, done_b, rdata_b, io_out_b, io_oeb_b, busy_b, m_b);
  endtask

  // Called at a negedge: apply inputs, advance the models, land on the next negedge and compare.
  task automatic step(input logic [3:0] r, input logic [3:0] w, input logic [31:0] d,
                      input logic [7:0] di);
    req = r; wr = w; wdata = d; io_in = di;
    m_a = model_step(m_a, TC_A, MH_A, r, w, d, di);
    m_b = model_step(m_b, TC_B, MH_B, r, w, d, di);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0, 4'b0, 32'b0, 8'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] seq [$];
    logic [3:0] prev_g, nreq, nwr, got_g;
    int         gap, min_gap;
    bit         seen_drive, released;

    rst = 1'b1; req = '0; wr = '0; wdata = '0; io_in = '0;
    m_a = model_reset(); m_b = model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("reset_oeb", 32'(io_oeb_a), 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    compare_all();

    // Round robin from pointer 0 with all requesters held.
    prev_g = '0; gap = 0; min_gap = 999; seen_drive = 1'b0;
    for (int c = 0; c < 90; c++) begin
      step(4'b1111, 4'b1111, $urandom, 8'($urandom));
      if (grant_a != prev_g && grant_a != 4'b0) seq.push_back(grant_a);
      prev_g = grant_a;
      if (io_oeb_a != 8'hFF) begin
        if (seen_drive && gap > 0 && gap < min_gap) min_gap = gap;
        gap = 0; seen_drive = 1'b1;
      end else if (seen_drive) begin
        gap++;
      end
    end
    for (int i = 0; i < 5; i++)
      check($sformatf("rr_order_%0d", i), 32'((i < seq.size()) ? seq[i] : 4'b0),
            32'(4'b0001 << (i % N)));
    check("rr_min_gap_ge2", 32'(min_gap >= 2 && min_gap != 999), 32'd1);
    idle(6);

    // Single write from requester 2.
    step(4'b0100, 4'b0100, 32'h00A5_0000, 8'h00);
    check("wr_grant_c1", 32'(grant_a), 32'(4'b0100));
    step(4'b0100, 4'b0100, 32'h00A5_0000, 8'h00);
    check("wr_oeb_c2", 32'(io_oeb_a), 32'hFF);
    step(4'b0100, 4'b0100, 32'h00A5_0000, 8'h00);
    check("wr_oeb_c3", 32'(io_oeb_a), 32'h00);
    check("wr_out_c3", 32'(io_out_a), 32'hA5);
    step(4'b0100, 4'b0100, 32'h00A5_0000, 8'h00);
    step(4'b0000, 4'b0100, 32'h00A5_0000, 8'h00);
    check("wr_done", 32'(done_a), 32'(4'b0100));
    check("wr_release_oeb", 32'(io_oeb_a), 32'hFF);
    idle(6);

    // Read by requester 1.
    for (int c = 1; c <= 5; c++) begin
      step(4'b0010, 4'b0000, $urandom, 8'h3C);
      check($sformatf("rd_oeb_c%0d", c), 32'(io_oeb_a), 32'hFF);
      if (c == 1) check("rd_grant_c1", 32'(grant_a), 32'(4'b0010));
      if (c == 3) check("rd_rdata_c3", 32'(rdata_a), 32'h3C);
    end
    idle(6);

    // Abort during a 3-cycle turnaround (instance b).
    step(4'b0001, 4'b0001, 32'h0000_00FF, 8'h00);
    check("abort_oeb_c1", 32'(io_oeb_b), 32'hFF);
    step(4'b0001, 4'b0001, 32'h0000_00FF, 8'h00);
    check("abort_oeb_c2", 32'(io_oeb_b), 32'hFF);
    step(4'b0000, 4'b0001, 32'h0000_00FF, 8'h00);
    check("abort_done_c3", 32'(done_b), 32'(4'b0001));
    check("abort_busy_c3", 32'(busy_b), 32'd0);
    check("abort_oeb_c3", 32'(io_oeb_b), 32'hFF);
    idle(6);

    // Pointer wrap: owner 3 force-released while req=1001 -> next grant goes to 0.
    repeat (4) step(4'b1000, 4'b1001, $urandom, 8'($urandom));
    check("wrap_owner3", 32'(grant_a), 32'(4'b1000));
    released = 1'b0; got_g = '0;
    for (int c = 0; c < 40 && got_g == 4'b0; c++) begin
      step(4'b1001, 4'b1001, $urandom, 8'($urandom));
      if (grant_a == 4'b0) released = 1'b1;
      else if (released) got_g = grant_a;
    end
    check("wrap_next_grant", 32'(got_g), 32'(4'b0001));
    idle(6);

    // Asynchronous reset while instance a is driving the pins.
    repeat (4) step(4'b0100, 4'b0100, 32'h005A_0000, 8'h00);
    check("pre_rst_driving", 32'(io_oeb_a), 32'h00);
    rst = 1'b1;
    #1;
    check("rst_oeb", 32'(io_oeb_a), 32'hFF);
    check("rst_grant", 32'(grant_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    req = '0; wr = '0;
    m_a = model_reset(); m_b = model_reset();
    @(negedge clk);
    check("rst_no_done", 32'(done_a), 32'd0);
    compare_all();
    rst = 1'b0;
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < N; i++) rem[i] = 0;
    nwr = '0;
    for (int c = 0; c < 1500; c++) begin
      nreq = req;
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (rem[i] <= 1) nreq[i] = 1'b0;
          else rem[i] = rem[i] - 1;
        end else if ($urandom_range(0, 3) == 0) begin
          nreq[i] = 1'b1;
          rem[i]  = int'($urandom_range(1, 25));
          nwr[i]  = 1'($urandom_range(0, 1));
        end
      end
      step(nreq, nwr, $urandom, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
